fp_result_pack: RTL and testbench

Parametrised result-packing and exception-flag stage for the pipelined floating-point units; successor to the single-precision multiplier's output stage. It takes the normalised sign, exponent, mantissa and raw exception indications from the datapath, delays them through a configurable, stallable pipeline with valid/ready flow control, and applies IEEE-754 special-case packing. Packing covers NaN, rounding-mode-aware overflow, denormal and zero. It drives the packed result, per-result flags and sticky accumulated flags to the FPU top level.

---
 rtl/fp_pkg.sv | 33 +++
 rtl/fp_pipe_stage.sv | 42 ++++
 rtl/fp_result_pack.sv | 163 ++++++++++++++++
 tb/tb_fp_result_pack.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared floating-point definitions: rounding modes, sticky-flag bit positions
// and width-derived exponent/mantissa constants.
package fp_pkg;

  typedef enum logic [1:0] {
    RM_RNE = 2'd0,
    RM_RTZ = 2'd1,
    RM_RUP = 2'd2,
    RM_RDN = 2'd3
  } rm_e;

  // Sticky vector layout is {nv, of, uf, nx, zf}.
  localparam int unsigned FLG_ZF = 0;
  localparam int unsigned FLG_NX = 1;
  localparam int unsigned FLG_UF = 2;
  localparam int unsigned FLG_OF = 3;
  localparam int unsigned FLG_NV = 4;
  localparam int unsigned FLG_W  = 5;

  function automatic logic [31:0] all_ones(input int unsigned w);
    logic [31:0] r;
    r = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i < w) r[i] = 1'b1;
    end
    return r;
  endfunction

  function automatic logic [31:0] max_finite_exp(input int unsigned w);
    return all_ones(w) - 32'd1;
  endfunction

endpackage

// File: rtl/fp_pipe_stage.sv
// Single valid/ready register slice; loads when empty or when its successor loads.
module fp_pipe_stage #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [W-1:0] data_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  assign ready_o = !valid_q || ready_i;
  assign valid_o = valid_q;
  assign data_o  = data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (ready_o) begin
      valid_d = valid_i;
      // Payload only moves with a real beat so bubbles leave the data untouched.
      if (valid_i) data_d = data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/fp_result_pack.sv
// Result-packing stage: stallable alignment pipeline, IEEE-754 special-case
// packing on the last payload stage, registered output and sticky flags.
module fp_result_pack
  import fp_pkg::*;
#(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23,
  parameter int unsigned DEPTH = 3
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [EXP_W-1:0] in_exp,
  input  logic [MAN_W:0]   in_man,
  input  logic [1:0]       in_rm,
  input  logic             in_zero,
  input  logic             in_ovf,
  input  logic             in_unf,
  input  logic             in_inv,
  input  logic             in_inx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sign,
  output logic [EXP_W-1:0] out_exp,
  output logic [MAN_W-1:0] out_man,
  output logic             out_zf,
  output logic             out_of,
  output logic             out_uf,
  output logic             out_nv,
  output logic             out_nx,
  output logic [4:0]       sticky_flags,
  input  logic             flag_clr
);

  localparam int unsigned PW = 1 + EXP_W + MAN_W + 2 + 5;
  localparam int unsigned OW = 1 + EXP_W + MAN_W + FLG_W;

  localparam logic [EXP_W-1:0] EXP_ONES = EXP_W'(all_ones(EXP_W));
  localparam logic [EXP_W-1:0] EXP_MAXF = EXP_W'(max_finite_exp(EXP_W));
  localparam logic [MAN_W-1:0] MAN_ONES = MAN_W'(all_ones(MAN_W));

  // The hidden bit never reaches the packed result, so it is not carried.
  logic hidden_unused;
  assign hidden_unused = in_man[MAN_W];

  logic [PW-1:0] pay [0:DEPTH];
  logic          vld [0:DEPTH+1];
  logic [OW-1:0] pk_pay, out_pay;

  assign pay[0] = {in_sign, in_exp, in_man[MAN_W-1:0], in_rm,
                   in_zero, in_ovf, in_unf, in_inv, in_inx};
  assign vld[0] = in_valid;

  for (genvar k = 0; k <= DEPTH; k++) begin : g_stg
    logic r_o, r_i;
    if (k == DEPTH) begin : g_rlast
      assign r_i = out_ready;
    end else begin : g_rmid
      assign r_i = g_stg[k+1].r_o;
    end

    if (k < DEPTH) begin : g_pay
      fp_pipe_stage #(.W(PW)) u_stage (
        .clk_i  (CLK),
        .rst_i  (RST),
        .valid_i(vld[k]),
        .ready_o(r_o),
        .data_i (pay[k]),
        .valid_o(vld[k+1]),
        .ready_i(r_i),
        .data_o (pay[k+1])
      );
    end else begin : g_out
      fp_pipe_stage #(.W(OW)) u_stage (
        .clk_i  (CLK),
        .rst_i  (RST),
        .valid_i(vld[k]),
        .ready_o(r_o),
        .data_i (pk_pay),
        .valid_o(vld[k+1]),
        .ready_i(r_i),
        .data_o (out_pay)
      );
    end
  end

  assign in_ready  = g_stg[0].r_o;
  assign out_valid = vld[DEPTH+1];

  logic             l_sign, l_zero, l_ovf, l_unf, l_inv, l_inx;
  logic [EXP_W-1:0] l_exp;
  logic [MAN_W-1:0] l_man;
  logic [1:0]       l_rm;

  assign {l_sign, l_exp, l_man, l_rm, l_zero, l_ovf, l_unf, l_inv, l_inx} = pay[DEPTH];

  logic             ovf_inf;
  logic [EXP_W-1:0] pk_exp;
  logic [MAN_W-1:0] pk_man;
  logic [FLG_W-1:0] pk_flags;

  always_comb begin
    unique case (rm_e'(l_rm))
      RM_RNE:  ovf_inf = 1'b1;
      RM_RUP:  ovf_inf = !l_sign;
      RM_RDN:  ovf_inf = l_sign;
      default: ovf_inf = 1'b0;
    endcase

    pk_exp = l_exp;
    pk_man = l_man;
    if (l_inv) begin
      pk_exp = EXP_ONES;
      pk_man = MAN_ONES;
    end else if (l_ovf) begin
      pk_exp = ovf_inf ? EXP_ONES : EXP_MAXF;
      pk_man = ovf_inf ? '0 : MAN_ONES;
    end else if (l_unf) begin
      pk_exp = '0;
    end

    pk_flags         = '0;
    pk_flags[FLG_ZF] = ((pk_exp == '0) && (pk_man == '0)) || l_zero;
    pk_flags[FLG_NV] = l_inv;
    pk_flags[FLG_OF] = !l_inv && l_ovf;
    pk_flags[FLG_UF] = !l_inv && !l_ovf && l_unf && !pk_flags[FLG_ZF];
    pk_flags[FLG_NX] = l_inx || (!l_inv && l_ovf);
  end

  assign pk_pay = {l_sign, pk_exp, pk_man, pk_flags};

  logic [FLG_W-1:0] out_flags;
  assign {out_sign, out_exp, out_man, out_flags} = out_pay;
  assign out_zf = out_flags[FLG_ZF];
  assign out_nx = out_flags[FLG_NX];
  assign out_uf = out_flags[FLG_UF];
  assign out_of = out_flags[FLG_OF];
  assign out_nv = out_flags[FLG_NV];

  logic             out_hs;
  logic [FLG_W-1:0] sticky_q, sticky_d;

  assign out_hs = out_valid && out_ready;

  always_comb begin
    sticky_d = sticky_q;
    if (flag_clr) begin
      sticky_d = out_hs ? out_flags : '0;
    end else if (out_hs) begin
      sticky_d = sticky_q | out_flags;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) sticky_q <= '0;
    else     sticky_q <= sticky_d;
  end

  assign sticky_flags = sticky_q;

endmodule

// File: tb/tb_fp_result_pack.sv
// Self-checking bench for fp_result_pack (EXP_W=8, MAN_W=23, DEPTH=3).
module tb_fp_result_pack;

  localparam int EW = 8;
  localparam int MW = 23;
  localparam int DP = 3;

  typedef struct packed {
    logic        sgn;
    logic [7:0]  ex;
    logic [23:0] mn;
    logic [1:0]  rm;
    logic        zr, ov, un, iv, ix;
  } beat_t;

  logic        CLK = 1'b0;
  logic        RST, in_valid, in_ready, in_sign;
  logic [7:0]  in_exp;
  logic [23:0] in_man;
  logic [1:0]  in_rm;
  logic        in_zero, in_ovf, in_unf, in_inv, in_inx;
  logic        out_valid, out_ready, out_sign;
  logic [7:0]  out_exp;
  logic [22:0] out_man;
  logic        out_zf, out_of, out_uf, out_nv, out_nx;
  logic [4:0]  sticky_flags;
  logic        flag_clr;

  fp_result_pack #(.EXP_W(EW), .MAN_W(MW), .DEPTH(DP)) dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_man(in_man), .in_rm(in_rm),
    .in_zero(in_zero), .in_ovf(in_ovf), .in_unf(in_unf), .in_inv(in_inv),
    .in_inx(in_inx), .out_valid(out_valid), .out_ready(out_ready),
    .out_sign(out_sign), .out_exp(out_exp), .out_man(out_man),
    .out_zf(out_zf), .out_of(out_of), .out_uf(out_uf), .out_nv(out_nv),
    .out_nx(out_nx), .sticky_flags(sticky_flags), .flag_clr(flag_clr)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int passes = 0;

  bit          ihs, ohs, ov;
  logic [36:0] osnap;

  // Result word: {sign, exp, man, nv, of, uf, nx, zf}.
  function automatic logic [36:0] cur_out();
    return {out_sign, out_exp, out_man, out_nv, out_of, out_uf, out_nx, out_zf};
  endfunction

  function automatic logic [36:0] ref_pack(input beat_t b);
    int e, m;
    bit nv, of, uf, nx, zf, to_inf;
    logic [7:0]  e8;
    logic [22:0] m23;
    int maxe = (1 << EW) - 1;
    int maxm = (1 << MW) - 1;
    to_inf = (b.rm == 2'd0) || (b.rm == 2'd2 && !b.sgn) || (b.rm == 2'd3 && b.sgn);
    if (b.iv) begin
      e = maxe; m = maxm;
    end else if (b.ov) begin
      e = to_inf ? maxe : maxe - 1;
      m = to_inf ? 0 : maxm;
    end else if (b.un) begin
      e = 0; m = int'(b.mn) % (1 << MW);
    end else begin
      e = int'(b.ex); m = int'(b.mn) % (1 << MW);
    end
    nv = b.iv;
    of = !b.iv && b.ov;
    zf = (e == 0 && m == 0) || b.zr;
    uf = !b.iv && !b.ov && b.un && !zf;
    nx = b.ix || of;
    e8  = 8'(e);
    m23 = 23'(m);
    return {b.sgn, e8, m23, nv, of, uf, nx, zf};
  endfunction

  function automatic beat_t rand_beat();
    beat_t b;
    b.sgn = 1'($urandom);
    b.ex  = 8'($urandom);
    b.mn  = {1'b1, 23'($urandom)};
    b.rm  = 2'($urandom);
    b.zr  = ($urandom % 8) == 0;
    b.ov  = ($urandom % 6) == 0;
    b.un  = ($urandom % 6) == 0;
    b.iv  = ($urandom % 8) == 0;
    b.ix  = ($urandom % 3) == 0;
    if (b.un && ($urandom % 2) == 1) b.mn[22:0] = '0;
    if (($urandom % 10) == 0) begin b.ex = '0; b.mn = '0; end
    return b;
  endfunction

  function automatic beat_t mk(input bit s, input logic [7:0] e, input logic [23:0] m,
                               input logic [1:0] rm, input logic [4:0] f);
    beat_t b;
    b.sgn = s; b.ex = e; b.mn = m; b.rm = rm;
    {b.zr, b.ov, b.un, b.iv, b.ix} = f;
    return b;
  endfunction

  task automatic drive(input beat_t b);
    in_sign = b.sgn; in_exp = b.ex; in_man = b.mn; in_rm = b.rm;
    {in_zero, in_ovf, in_unf, in_inv, in_inx} = {b.zr, b.ov, b.un, b.iv, b.ix};
  endtask

  // Called just after a falling edge with inputs already set; samples, then
  // advances through the rising edge to the next falling edge.
  task automatic tick();
    #1;
    ihs   = in_valid && in_ready;
    ohs   = out_valid && out_ready;
    ov    = out_valid;
    osnap = cur_out();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic send_one(input beat_t b, output int lat, output logic [36:0] r);
    drive(b);
    in_valid = 1'b1;
    out_ready = 1'b1;
    lat = -1;
    r = '0;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (ihs) break;
    end
    in_valid = 1'b0;
    for (int j = 1; j <= 20; j++) begin
      tick();
      if (ohs) begin lat = j; r = osnap; break; end
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flag_clr = 1'b0;
    drive(rand_beat());
    tick(); tick();
    RST = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b want=0", out_valid); else passes++;
    checks++;
    if (cur_out() !== 37'd0) $display("FAIL reset_out_fields got=%h want=0", cur_out()); else passes++;
    checks++;
    if (sticky_flags !== 5'd0) $display("FAIL reset_sticky got=%b want=00000", sticky_flags); else passes++;
    checks++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b want=1", in_ready); else passes++;
    @(negedge CLK);
  endtask

  task automatic test_normal();
    int lat;
    logic [36:0] r;
    beat_t b;
    b = mk(1'b0, 8'h80, 24'hC00000, 2'd0, 5'b00000);
    send_one(b, lat, r);
    checks++;
    if (lat !== DP + 1) $display("FAIL normal_latency got=%0d want=%0d", lat, DP + 1); else passes++;
    checks++;
    if (r !== {1'b0, 8'h80, 23'h400000, 5'b00000})
      $display("FAIL normal_value got=%h want=%h", r, {1'b0, 8'h80, 23'h400000, 5'b00000});
    else passes++;
  endtask

  task automatic test_overflow();
    int lat;
    logic [36:0] r, w;
    beat_t b;
    bit sg[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    for (int k = 0; k < 4; k++) begin
      b = mk(sg[k], 8'($urandom), {1'b1, 23'($urandom)}, 2'(k), 5'b01000);
      w = ref_pack(b);
      send_one(b, lat, r);
      checks++;
      if (r !== w) $display("FAIL overflow_rm%0d got=%h want=%h", k, r, w); else passes++;
    end
  endtask

  task automatic test_special();
    int lat;
    logic [36:0] r, w;
    beat_t b[3];
    b[0] = mk(1'b1, 8'h42, 24'h812345, 2'd0, 5'b01010);
    b[1] = mk(1'b0, 8'h05, 24'h800000, 2'd1, 5'b00100);
    b[2] = mk(1'b0, 8'h05, 24'h800123, 2'd1, 5'b00100);
    for (int k = 0; k < 3; k++) begin
      w = ref_pack(b[k]);
      send_one(b[k], lat, r);
      checks++;
      if (r !== w) $display("FAIL special_%0d got=%h want=%h", k, r, w); else passes++;
    end
  endtask

  task automatic test_backpressure();
    beat_t bp[6];
    logic [36:0] q[$];
    logic [36:0] hold, w;
    int acc = 0, got = 0, unstable = 0;
    bit have_hold = 0;
    for (int k = 0; k < 6; k++) bp[k] = rand_beat();
    out_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      in_valid = (acc < 6);
      drive(bp[acc < 6 ? acc : 5]);
      tick();
      if (ihs) begin q.push_back(ref_pack(bp[acc])); acc++; end
      if (ov) begin
        if (have_hold && osnap !== hold) unstable++;
        hold = osnap; have_hold = 1;
      end else if (have_hold) unstable++;
    end
    #1;
    checks++;
    if (acc !== DP + 1) $display("FAIL bp_accepted got=%0d want=%0d", acc, DP + 1); else passes++;
    checks++;
    if (in_ready !== 1'b0) $display("FAIL bp_in_ready got=%b want=0", in_ready); else passes++;
    checks++;
    if (unstable !== 0 || !have_hold) $display("FAIL bp_hold_stable got=%0d changes want=0", unstable); else passes++;
    out_ready = 1'b1;
    for (int c = 0; c < 40 && got < 6; c++) begin
      in_valid = (acc < 6);
      drive(bp[acc < 6 ? acc : 5]);
      tick();
      if (ihs) begin q.push_back(ref_pack(bp[acc])); acc++; end
      if (ohs) begin
        w = (q.size() > 0) ? q.pop_front() : 37'h0;
        checks++;
        if (osnap !== w) $display("FAIL bp_result_%0d got=%h want=%h", got, osnap, w); else passes++;
        got++;
      end
    end
    in_valid = 1'b0;
    tick(); tick(); tick(); tick(); tick();
    checks++;
    if (got !== 6 || ohs) $display("FAIL bp_count got=%0d want=6", got); else passes++;
  endtask

  task automatic test_sticky();
    int lat, n;
    logic [36:0] r, w;
    beat_t b3;
    flag_clr = 1'b1; out_ready = 1'b1; in_valid = 1'b0;
    tick();
    flag_clr = 1'b0;
    checks++;
    if (sticky_flags !== 5'd0) $display("FAIL sticky_clear got=%b want=00000", sticky_flags); else passes++;
    send_one(mk(1'b0, 8'h10, 24'h9ABCDE, 2'd0, 5'b00001), lat, r);
    send_one(mk(1'b1, 8'h20, 24'h800001, 2'd0, 5'b00010), lat, r);
    checks++;
    if (sticky_flags !== 5'b10010) $display("FAIL sticky_accum got=%b want=10010", sticky_flags); else passes++;
    b3 = mk(1'b0, 8'h70, 24'hFFFFFF, 2'd1, 5'b01000);
    w = ref_pack(b3);
    out_ready = 1'b0;
    drive(b3);
    in_valid = 1'b1;
    for (n = 0; n < 20; n++) begin tick(); if (ihs) break; end
    in_valid = 1'b0;
    for (n = 0; n < 20 && !out_valid; n++) tick();
    out_ready = 1'b1; flag_clr = 1'b1;
    tick();
    flag_clr = 1'b0; out_ready = 1'b0;
    checks++;
    if (!ohs) $display("FAIL sticky_clr_hs got=%b want=1", ohs); else passes++;
    checks++;
    if (sticky_flags !== w[4:0]) $display("FAIL sticky_clr_coincide got=%b want=%b", sticky_flags, w[4:0]); else passes++;
  endtask

  task automatic test_reset_midstream();
    int stale = 0;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(mk(1'b0, 8'h33, 24'hA00000, 2'd0, 5'b00011));
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    RST = 1'b1;
    tick();
    RST = 1'b0;
    checks++;
    if (out_valid !== 1'b0) $display("FAIL rst_mid_out_valid got=%b want=0", out_valid); else passes++;
    checks++;
    if (sticky_flags !== 5'd0) $display("FAIL rst_mid_sticky got=%b want=00000", sticky_flags); else passes++;
    for (int c = 0; c < 10; c++) begin tick(); if (ov) stale++; end
    checks++;
    if (stale !== 0) $display("FAIL rst_mid_stale got=%0d want=0", stale); else passes++;
  endtask

  task automatic test_random();
    logic [36:0] q[$];
    logic [36:0] w, prev;
    beat_t cur;
    bit prev_stall = 0;
    int sent = 0, recv = 0, unstable = 0;
    cur = rand_beat();
    for (int c = 0; c < 400 && (sent < 60 || q.size() > 0); c++) begin
      in_valid  = (sent < 60) && (($urandom % 10) < 7);
      out_ready = (sent >= 60) || (($urandom % 10) < 6);
      drive(cur);
      tick();
      if (prev_stall && (!ov || osnap !== prev)) unstable++;
      prev_stall = ov && !ohs;
      prev = osnap;
      if (ihs) begin q.push_back(ref_pack(cur)); sent++; cur = rand_beat(); end
      if (ohs) begin
        w = (q.size() > 0) ? q.pop_front() : 37'h0;
        checks++;
        if (osnap !== w) $display("FAIL rand_result_%0d got=%h want=%h", recv, osnap, w); else passes++;
        recv++;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (recv !== 60 || sent !== 60) $display("FAIL rand_count got=%0d want=60", recv); else passes++;
    checks++;
    if (unstable !== 0) $display("FAIL rand_hold_stable got=%0d want=0", unstable); else passes++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flag_clr = 1'b0;
    drive(mk(1'b0, 8'h00, 24'h000000, 2'd0, 5'b00000));
    @(negedge CLK);
    test_reset();
    test_normal();
    test_overflow();
    test_special();
    test_backpressure();
    test_sticky();
    test_reset_midstream();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
